sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter_pkg.sv | 12 +
 rtl/sprite_rom_arbiter_rr_pick.sv | 25 ++
 rtl/sprite_rom_arbiter.sv | 56 +++++
 tb/tb_sprite_rom_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_arb_pkg: shared defaults, grant index type and one-hot decode for the sprite ROM arbiter
package sprite_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 4;
  localparam int MAX_REQ = 8;
  typedef logic [2:0] idx_t;
  function automatic idx_t oh2idx(input logic [MAX_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < MAX_REQ; i++) if (oh[i]) oh2idx = idx_t'(i);
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: one-hot rotating-priority pick; search starts just after ptr and wraps
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic [N-1:0] gnt
);
  localparam int W = $clog2(N);
  logic [W-1:0] k;
  // Walk from lowest to highest priority so the last hit (ptr+1) wins
  always_comb begin
    gnt = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one synchronous sprite ROM among NUM_REQ readers
// Optional SPRITE_ARB_PRIO0_EN gives requester 0 strict priority over the rotating others.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      busy
);
  idx_t last_gnt;
  idx_t gidx;
  logic [ADDR_W-1:0] held_addr;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] rr_req;
  logic upd;
`ifdef SPRITE_ARB_PRIO0_EN
  // Player sprite bypasses rotation and never moves the pointer
  assign rr_req = req & ~NUM_REQ'(1);
  assign gnt = !reset_n ? '0 : req[0] ? NUM_REQ'(1) : pick;
  assign upd = |gnt && !gnt[0];
`else
  assign rr_req = req;
  assign gnt = reset_n ? pick : '0;
  assign upd = |gnt;
`endif
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(rr_req),
    .ptr(last_gnt),
    .gnt(pick)
  );
  assign gidx = oh2idx(MAX_REQ'(gnt));
  assign rom_address = |gnt ? req_addr[int'(gidx)*ADDR_W +: ADDR_W] : held_addr;
  assign rdata = rom_q;
  assign busy = |req || |rvalid;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rvalid <= '0;
      last_gnt <= idx_t'(NUM_REQ - 1);
      held_addr <= '0;
    end else begin
      rvalid <= gnt;
      if (upd) last_gnt <= gidx;
      if (|gnt) held_addr <= rom_address;
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed + random scoreboard bench; honours SPRITE_ARB_PRIO0_EN
module tb_sprite_rom_arbiter;
  logic vga_clk = 1'b0;
  logic reset_n;
  logic [3:0] req;
  logic [39:0] req_addr;
  logic [3:0] gnt, rvalid, rdata, rom_q;
  logic [9:0] rom_address;
  logic busy;
  typedef struct {logic [3:0] v; logic [3:0] d;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, m_ptr = 3;
  logic [9:0] m_hold = '0;
  int waitc[4] = '{0, 0, 0, 0};
  logic [3:0] og;
  logic [3:0] seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] pseq[3] = '{4'b0010, 4'b0100, 4'b1000};

  sprite_rom_arbiter dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .rom_address(rom_address), .rom_q(rom_q), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_f(input logic [9:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]} ^ 4'h5;
  endfunction

  always @(posedge vga_clk) rom_q <= rom_f(rom_address);

  function automatic logic [3:0] model_gnt(input logic [3:0] r, input int p);
    logic [7:0] dbl;
    logic [3:0] rr;
    rr = r;
`ifdef SPRITE_ARB_PRIO0_EN
    if (r[0]) return 4'b0001;
    rr = r & 4'b1110;
`endif
    dbl = {rr, rr} >> (p + 1);
    for (int j = 0; j < 4; j++) if (dbl[j]) return 4'b0001 << ((p + 1 + j) % 4);
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(output logic [3:0] o, input bit rst_after);
    logic [3:0] eg;
    logic [9:0] ea;
    exp_t e;
    int gi;
    @(negedge vga_clk);
    eg = model_gnt(req, m_ptr);
    o = gnt;
    chk("gnt", gnt, eg);
    gi = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
    ea = (eg != 0) ? req_addr[gi*10 +: 10] : m_hold;
    chk("rom_address", rom_address, ea);
    if (q.size() > 0) e = q.pop_front();
    else e = '{4'b0000, 4'b0000};
    chk("rvalid", rvalid, e.v);
    if (e.v != 0) chk("rdata", rdata, e.d);
    chk("busy", busy, (req != 0) || (e.v != 0));
`ifndef SPRITE_ARB_PRIO0_EN
    for (int i = 0; i < 4; i++) begin
      waitc[i] = (req[i] && !gnt[i]) ? waitc[i] + 1 : 0;
      if (req[i]) chk("max_wait", waitc[i] <= 3, 1);
    end
`endif
    if (rst_after) begin
      #1 reset_n = 1'b0;
      q.delete();
      m_ptr = 3;
      m_hold = '0;
    end else begin
      q.push_back('{eg, rom_f(ea)});
      if (eg != 0) m_hold = ea;
`ifdef SPRITE_ARB_PRIO0_EN
      if (eg != 0 && !eg[0]) m_ptr = gi;
`else
      if (eg != 0) m_ptr = gi;
`endif
    end
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req = 4'b1111;
    req_addr = {10'h3c1, 10'h2a7, 10'h11d, 10'h05e};
    repeat (2) begin
      @(negedge vga_clk);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_rvalid", rvalid, 4'b0000);
      chk("rst_addr", rom_address, 10'h000);
    end
    @(posedge vga_clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(og, 1'b0);
`ifndef SPRITE_ARB_PRIO0_EN
      chk("rr_seq", og, seq[k]);
`endif
    end
    req = 4'b0100;
    req_addr[20 +: 10] = 10'h155;
    for (int k = 0; k < 4; k++) begin
      cycle(og, 1'b0);
      chk("single_gnt", og, 4'b0100);
      chk("single_addr", rom_address, 10'h155);
      chk("single_rvalid", rvalid, 4'b0100);
    end
    req = 4'b0010;
    cycle(og, 1'b0);
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      cycle(og, 1'b0);
      chk("idle_hold", rom_address, 10'h11d);
    end
    req = 4'b0011;
    cycle(og, 1'b0);
    chk("ptr_keep", og, 4'b0001);
    req = 4'b0010;
    cycle(og, 1'b1);
    req = 4'b1111;
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_rvalid", rvalid, 4'b0000);
    reset_n = 1'b1;
    cycle(og, 1'b0);
    chk("post_rst_gnt", og, 4'b0001);
`ifdef SPRITE_ARB_PRIO0_EN
    for (int k = 0; k < 4; k++) begin
      cycle(og, 1'b0);
      chk("prio0", og, 4'b0001);
    end
    req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      cycle(og, 1'b0);
      chk("prio_rr", og, pseq[k]);
    end
`endif
    for (int k = 0; k < 1000; k++) begin
      req = 4'($urandom);
      req_addr = {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)};
      cycle(og, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
